// File: rtl/dot_product_ctrl_pkg.sv
// Shared types and default sizes for the dot-product sequencer.
package dot_pkg;
    localparam int ACC_W_DEF  = 28;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/dot_product_ctrl_valid_delay.sv
// DEPTH-cycle delay line for a single valid bit, synchronous active-high reset.
module valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/dot_product_ctrl.sv
// Sequencer for one signed dot product on the 2-stage MAC and operand SRAMs.
// Optional DOT_CYCLE_CNT_EN adds a per-job cycle count output.
module dot_product_ctrl
    import dot_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MEM_LAT = 1,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W:0]   len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mac_clr,
    output logic              mac_valid,
    input  logic [ACC_W-1:0]  mac_f,
    output logic [ACC_W-1:0]  res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
`ifdef DOT_CYCLE_CNT_EN
    ,
    output logic [15:0]       cycles
`endif
);
    localparam int DRAIN_N = MEM_LAT + MAC_LAT;
    localparam int DW      = $clog2(DRAIN_N + 1);

    state_t          state;
    logic [ADDR_W:0] len_q;
    logic [DW-1:0]   drain;
    logic            last_issue;
    logic            last_drain;

    // mem_addr doubles as the element counter; it wraps to 0 after a full-length job
    assign last_issue = ({1'b0, mem_addr} == (len_q - 1'b1));
    assign last_drain = (drain == DW'(DRAIN_N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            mac_clr     <= 1'b0;
            res         <= '0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            len_q       <= '0;
            drain       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        len_q       <= len;
                        state       <= CLEAR;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        mac_clr     <= 1'b1;
                    end
                end
                CLEAR: begin
                    mac_clr  <= 1'b0;
                    mem_addr <= '0;
                    if (len_q == '0) begin
                        res       <= '0;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mem_rd_en <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_addr <= mem_addr + 1'b1;
                    if (last_issue) begin
                        mem_rd_en <= 1'b0;
                        drain     <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_drain) begin
                        res       <= mac_f;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        drain <= drain + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand data arrives MEM_LAT cycles after the read strobe
    valid_delay #(.DEPTH(MEM_LAT)) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .din   (mem_rd_en),
        .dout  (mac_valid)
    );

`ifdef DOT_CYCLE_CNT_EN
    logic [15:0] cyc_cnt;
    logic        entering_done;

    assign entering_done = ((state == CLEAR) && (len_q == '0)) ||
                           ((state == DRAIN) && last_drain);

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
            cycles  <= '0;
        end else if ((state == IDLE) && start_valid) begin
            cyc_cnt <= 16'd1;
        end else if ((state != IDLE) && (state != DONE)) begin
            if (entering_done) cycles <= cyc_cnt;
            if (cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
        end
    end
`endif
endmodule
